// File: rtl/div_plus.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per cycle; result packs {remainder, quotient} with a one-cycle ready pulse.
module div_plus #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 div_sign,
  input  logic                 cancel_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 quot_neg_q, quot_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic                 s1, s2;
  logic [WIDTH-1:0]     abs1, abs2;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     rem_nx, quot_nx;
  logic [WIDTH-1:0]     rem_fix, quot_fix;

  // Registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  // Next state, iteration datapath and sign correction
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    ready_d    = 1'b0;

    s1   = div_sign & opdata1_i[WIDTH-1];
    s2   = div_sign & opdata2_i[WIDTH-1];
    abs1 = s1 ? WIDTH'(~opdata1_i + 1'b1) : opdata1_i;
    abs2 = s2 ? WIDTH'(~opdata2_i + 1'b1) : opdata2_i;

    // Trial subtract; bit WIDTH set means the shifted remainder is below the divisor
    trial = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvs_q};
    if (trial[WIDTH]) begin
      rem_nx  = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
      quot_nx = {quot_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nx  = trial[WIDTH-1:0];
      quot_nx = {quot_q[WIDTH-2:0], 1'b1};
    end
    rem_fix  = rem_neg_q  ? WIDTH'(~rem_nx + 1'b1)  : rem_nx;
    quot_fix = quot_neg_q ? WIDTH'(~quot_nx + 1'b1) : quot_nx;

    if (cancel_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            rem_d      = '0;
            quot_d     = abs1;
            dvs_d      = abs2;
            cnt_d      = '0;
            quot_neg_d = s1 ^ s2;
            rem_neg_d  = s1;
            if (opdata2_i == '0) begin
              state_d  = DONE;
              ready_d  = 1'b1;
              result_d = {opdata1_i, {WIDTH{1'b1}}};
            end else begin
              state_d  = BUSY;
            end
          end
        end
        BUSY: begin
          rem_d  = rem_nx;
          quot_d = quot_nx;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {rem_fix, quot_fix};
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_plus.sv
// Self-checking bench for div_plus: scoreboard of expected results popped on each ready pulse.
module tb_div_plus;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        div_sign;
  logic        cancel_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  div_plus #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .div_sign  (div_sign),
    .cancel_i  (cancel_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o)
  );

  // Reference model built on the simulator's own division operators
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] e);
    @(negedge clk);
    start_i   = 1'b1;
    div_sign  = s;
    opdata1_i = a;
    opdata2_i = b;
    sb.push_back(e);
  endtask

  // Cycles from the negedge after the call until ready_o is seen; -1 on timeout
  task automatic wait_ready(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 100 && cyc < 0; i++) begin
      @(negedge clk);
      if (ready_o) cyc = i;
    end
  endtask

  task automatic test_reset;
    logic [63:0] exp_v;
    rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; div_sign = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    exp_v = '0;
    checks++;
    if (result_o !== exp_v) begin errors++; $display("FAIL reset_result: got %h want %h", result_o, exp_v); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    int cyc;
    logic [63:0] exp_v;
    issue(32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL unsigned_early_ready: got %b want 0", ready_o); end
    opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h0000_0003; div_sign = 1'b1;
    wait_ready(cyc);
    checks++;
    if (cyc != 32) begin errors++; $display("FAIL unsigned_latency: got %0d want 32 (+1 already elapsed)", cyc); end
    exp_v = sb.pop_front();
    checks++;
    if (result_o !== exp_v) begin errors++; $display("FAIL unsigned_result: got %h want %h", result_o, exp_v); end
    start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL unsigned_pulse_width: got %b want 0", ready_o); end
    repeat (5) @(negedge clk);
    checks++;
    if (result_o !== exp_v) begin errors++; $display("FAIL unsigned_hold: got %h want %h", result_o, exp_v); end
  endtask

  task automatic test_signed_extremes;
    logic [31:0] ta [6] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] tb [6] = '{32'd2, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic        ts [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] te [6] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h1, 32'hFFFF_FFFD},
                            {32'h0, 32'hFFFF_FFFF}, {32'h0, 32'h8000_0000},
                            {32'h8000_0000, 32'h0}, {32'hFFFF_FFFF, 32'h3}};
    int cyc;
    logic [63:0] exp_v;
    for (int i = 0; i < 6; i++) begin
      issue(ta[i], tb[i], ts[i], te[i]);
      wait_ready(cyc);
      checks++;
      if (cyc != 33) begin errors++; $display("FAIL signed_latency[%0d]: got %0d want 33", i, cyc); end
      exp_v = sb.pop_front();
      checks++;
      if (result_o !== exp_v) begin errors++; $display("FAIL signed_result[%0d]: got %h want %h", i, result_o, exp_v); end
      start_i = 1'b0;
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] ta [3] = '{32'h1234_5678, 32'h1234_5678, 32'h8000_0005};
    logic        ts [3] = '{1'b1, 1'b0, 1'b1};
    int cyc;
    logic [63:0] exp_v;
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], 32'h0, ts[i], {ta[i], 32'hFFFF_FFFF});
      wait_ready(cyc);
      checks++;
      if (cyc != 1) begin errors++; $display("FAIL divzero_latency[%0d]: got %0d want 1", i, cyc); end
      exp_v = sb.pop_front();
      checks++;
      if (result_o !== exp_v) begin errors++; $display("FAIL divzero_result[%0d]: got %h want %h", i, result_o, exp_v); end
      start_i = 1'b0;
    end
  endtask

  task automatic test_cancel;
    int cyc;
    int seen;
    logic [63:0] exp_v;
    logic [63:0] prev;
    issue(32'd1000, 32'd10, 1'b0, {32'd0, 32'd100});
    wait_ready(cyc);
    prev = sb.pop_front();
    checks++;
    if (result_o !== prev) begin errors++; $display("FAIL cancel_setup: got %h want %h", result_o, prev); end
    start_i = 1'b0;
    @(negedge clk);
    start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3; div_sign = 1'b0;
    repeat (11) @(negedge clk);
    cancel_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    cancel_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL cancel_ready: got %b want 0", ready_o); end
    checks++;
    if (result_o !== prev) begin errors++; $display("FAIL cancel_result_kept: got %h want %h", result_o, prev); end
    issue(32'd50, 32'd5, 1'b0, {32'd0, 32'd10});
    wait_ready(cyc);
    checks++;
    if (cyc != 33) begin errors++; $display("FAIL cancel_restart_latency: got %0d want 33", cyc); end
    exp_v = sb.pop_front();
    checks++;
    if (result_o !== exp_v) begin errors++; $display("FAIL cancel_restart_result: got %h want %h", result_o, exp_v); end
    start_i = 1'b0;
    // start together with cancel in IDLE must not be accepted
    @(negedge clk);
    start_i = 1'b1; cancel_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd0;
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL cancel_with_start: got %0d ready pulses want 0", seen); end
  endtask

  task automatic test_rst_mid;
    int cyc;
    int seen;
    logic [63:0] exp_v;
    @(negedge clk);
    start_i = 1'b1; opdata1_i = 32'd12345; opdata2_i = 32'd17; div_sign = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1; cancel_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0; cancel_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", ready_o); end
    exp_v = '0;
    checks++;
    if (result_o !== exp_v) begin errors++; $display("FAIL rst_mid_result: got %h want %h", result_o, exp_v); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_mid_spurious: got %0d ready pulses want 0", seen); end
    issue(32'd12345, 32'd17, 1'b1, {32'd3, 32'd726});
    wait_ready(cyc);
    checks++;
    if (cyc != 33) begin errors++; $display("FAIL rst_mid_restart_latency: got %0d want 33", cyc); end
    exp_v = sb.pop_front();
    checks++;
    if (result_o !== exp_v) begin errors++; $display("FAIL rst_mid_restart_result: got %h want %h", result_o, exp_v); end
    start_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [63:0] exp_v;
    issue(32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
    wait_ready(cyc);
    checks++;
    if (cyc != 33) begin errors++; $display("FAIL b2b_first_latency: got %0d want 33", cyc); end
    exp_v = sb.pop_front();
    checks++;
    if (result_o !== exp_v) begin errors++; $display("FAIL b2b_first_result: got %h want %h", result_o, exp_v); end
    // start stays high through DONE; new operands must only be taken in the following IDLE
    opdata1_i = 32'd81; opdata2_i = 32'd9;
    sb.push_back({32'd0, 32'd9});
    wait_ready(cyc);
    checks++;
    if (cyc != 34) begin errors++; $display("FAIL b2b_second_latency: got %0d want 34", cyc); end
    exp_v = sb.pop_front();
    checks++;
    if (result_o !== exp_v) begin errors++; $display("FAIL b2b_second_result: got %h want %h", result_o, exp_v); end
    start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width: got %b want 0", ready_o); end
  endtask

  task automatic test_random;
    int cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp_v;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 40)) : $urandom;
      if (i == 3) b = 32'h0;
      s = 1'($urandom_range(0, 1));
      issue(a, b, s, model(a, b, s));
      wait_ready(cyc);
      checks++;
      if (cyc != ((b == 32'h0) ? 1 : 33)) begin
        errors++; $display("FAIL random_latency[%0d]: got %0d cycles for %h/%h", i, cyc, a, b);
      end
      exp_v = sb.pop_front();
      checks++;
      if (result_o !== exp_v) begin
        errors++; $display("FAIL random_result[%0d]: %h/%h s=%b got %h want %h", i, a, b, s, result_o, exp_v);
      end
      start_i = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed_extremes();
    test_div_zero();
    test_cancel();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
